// File: rtl/oreg_drain_pkg.sv
// Shared types and sizing for the systolic-array output drain.
package oreg_drain_pkg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned COLS  = 4;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNTW  = 16;
  localparam int unsigned PTRW  = $clog2(DEPTH) + 1;
  localparam int unsigned IDXW  = PTRW - 1;

  typedef logic signed [WIDTH-1:0] col_t;
  typedef col_t [COLS-1:0] row_t;

  // Storage slot addressed by a FIFO pointer (wrap bit dropped).
  function automatic logic [IDXW-1:0] ptr_idx(input logic [PTRW-1:0] p);
    return p[IDXW-1:0];
  endfunction

endpackage

// File: rtl/oreg_drain_if.sv
// Array-side and writer-side bus of the output drain.
interface oreg_drain_if;
  import oreg_drain_pkg::*;

  logic [COLS-1:0] i_valid;
  row_t            i_data;
  logic            o_stall;
  logic            o_valid;
  logic            i_ready;
  row_t            o_data;
  logic            o_ovf;
  logic [CNTW-1:0] o_rows;

  modport master (
    output i_valid, i_data, i_ready,
    input  o_stall, o_valid, o_data, o_ovf, o_rows
  );

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_stall, o_valid, o_data, o_ovf, o_rows
  );

endinterface

// File: rtl/oreg_drain_row_fifo.sv
// Synchronous row FIFO; extra pointer bit separates full from empty.
module oreg_drain_row_fifo
  import oreg_drain_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic push,
  input  logic pop,
  input  row_t wdata,
  output row_t rdata,
  output logic full,
  output logic empty
);

  row_t            mem [DEPTH];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic            do_push;
  logic            do_pop;

  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[PTRW-1] != rd_ptr[PTRW-1]) &&
              (ptr_idx(wr_ptr) == ptr_idx(rd_ptr));
    do_push = push && !full;
    do_pop  = pop && !empty;
    rdata   = mem[ptr_idx(rd_ptr)];
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[ptr_idx(wr_ptr)] <= wdata;
        wr_ptr               <= wr_ptr + PTRW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTRW'(1);
    end
  end

endmodule

// File: rtl/oreg_drain.sv
// Deskews per-column array results into aligned rows and streams them out
// through a small row FIFO, back-pressuring the array when it fills.
module oreg_drain
  import oreg_drain_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  oreg_drain_if.slave  bus
);

  logic [COLS-1:0] flag;
  row_t            hold;
  logic            ovf;
  logic [CNTW-1:0] rows;

  logic            full;
  logic            empty;
  logic            complete;
  logic            commit;
  logic            pop;
  logic [COLS-1:0] strobe;
  logic [COLS-1:0] take;

  // A strobe on a filled column is accepted only when that row commits now.
  always_comb begin
    strobe   = {COLS{en}} & bus.i_valid;
    complete = &flag;
    commit   = complete && !full;
    take     = strobe & (~flag | {COLS{commit}});
    pop      = !empty && bus.i_ready;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      flag <= '0;
      hold <= '0;
      ovf  <= 1'b0;
      rows <= '0;
    end else begin
      for (int unsigned c = 0; c < COLS; c++) begin
        if (take[c]) begin
          hold[c] <= bus.i_data[c];
          flag[c] <= 1'b1;
        end else if (commit) begin
          flag[c] <= 1'b0;
        end
      end
      if (|(strobe & ~take)) ovf <= 1'b1;
      if (pop) rows <= rows + CNTW'(1);
    end
  end

  oreg_drain_row_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (commit),
    .pop   (pop),
    .wdata (hold),
    .rdata (bus.o_data),
    .full  (full),
    .empty (empty)
  );

  assign bus.o_stall = complete && full;
  assign bus.o_valid = !empty;
  assign bus.o_ovf   = ovf;
  assign bus.o_rows  = rows;

endmodule

// File: tb/tb_oreg_drain.sv
// Directed bench for oreg_drain with hand-computed expected rows.
module tb_oreg_drain;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic clr;
  int   total  = 0;
  int   passed = 0;
  int   fails  = 0;

  oreg_drain_if bus ();

  oreg_drain dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] iv, input logic [31:0] d);
    bus.i_valid = iv;
    bus.i_data  = d;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; clr = 1'b0;
    bus.i_ready = 1'b0;
    drive(4'h0, 32'h0);
    step(); step();
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_data",  bus.o_data,       32'd0);
    chk("rst_stall", 32'(bus.o_stall), 32'd0);
    chk("rst_ovf",   32'(bus.o_ovf),   32'd0);
    chk("rst_rows",  32'(bus.o_rows),  32'd0);
    rst = 1'b0;

    // Skewed row 1,-2,3,-4
    bus.i_ready = 1'b1;
    drive(4'h1, 32'h0000_0001); step();
    drive(4'h2, 32'h0000_FE00); step();
    drive(4'h4, 32'h0003_0000); step();
    drive(4'h8, 32'hFC00_0000); step();
    drive(4'h0, 32'h0);
    chk("skew_early", 32'(bus.o_valid), 32'd0);
    step();
    chk("skew_valid", 32'(bus.o_valid), 32'd1);
    chk("skew_data",  bus.o_data,       32'hFC03_FE01);
    step();
    chk("skew_once",  32'(bus.o_valid), 32'd0);
    chk("skew_rows",  32'(bus.o_rows),  32'd1);

    // Back-pressure with three rows
    bus.i_ready = 1'b0;
    drive(4'hF, 32'h0D0C_0B0A); step();
    drive(4'hF, 32'h1716_1514); step();
    drive(4'hF, 32'h2120_1F1E);
    chk("bp_valid", 32'(bus.o_valid), 32'd1);
    chk("bp_row1",  bus.o_data,       32'h0D0C_0B0A);
    step();
    drive(4'h0, 32'h0);
    chk("bp_stall",  32'(bus.o_stall), 32'd1);
    chk("bp_hold1",  bus.o_data,       32'h0D0C_0B0A);
    step();
    chk("bp_stall2", 32'(bus.o_stall), 32'd1);
    chk("bp_hold2",  bus.o_data,       32'h0D0C_0B0A);
    bus.i_ready = 1'b1;
    step();
    chk("bp_unstall", 32'(bus.o_stall), 32'd0);
    chk("bp_row2",    bus.o_data,       32'h1716_1514);
    chk("bp_rows2",   32'(bus.o_rows),  32'd2);
    step();
    chk("bp_valid3",  32'(bus.o_valid), 32'd1);
    chk("bp_row3",    bus.o_data,       32'h2120_1F1E);
    step();
    chk("bp_drained", 32'(bus.o_valid), 32'd0);
    chk("bp_rows",    32'(bus.o_rows),  32'd4);
    chk("bp_ovf",     32'(bus.o_ovf),   32'd0);

    // Overlap: column 0 of the next row arrives on the commit cycle
    drive(4'hF, 32'h4433_2211); step();
    drive(4'h1, 32'h0000_0055); step();
    chk("ov_row1", bus.o_data, 32'h4433_2211);
    drive(4'hE, 32'h8877_6600); step();
    drive(4'h0, 32'h0);
    chk("ov_gap",  32'(bus.o_valid), 32'd0);
    step();
    chk("ov_valid", 32'(bus.o_valid), 32'd1);
    chk("ov_row2",  bus.o_data,       32'h8877_6655);
    chk("ov_ovf",   32'(bus.o_ovf),   32'd0);
    step();
    chk("ov_rows",  32'(bus.o_rows),  32'd6);

    // Overflow: column 2 strobes twice before column 3
    drive(4'h3, 32'h0000_0201); step();
    drive(4'h4, 32'h0007_0000); step();
    drive(4'h4, 32'h0009_0000); step();
    chk("of_set", 32'(bus.o_ovf), 32'd1);
    drive(4'h8, 32'h0A00_0000); step();
    drive(4'h0, 32'h0);
    chk("of_nov", 32'(bus.o_valid), 32'd0);
    step();
    chk("of_valid", 32'(bus.o_valid), 32'd1);
    chk("of_data",  bus.o_data,       32'h0A07_0201);
    step();
    chk("of_sticky", 32'(bus.o_ovf),  32'd1);
    chk("of_rows",   32'(bus.o_rows), 32'd7);

    // Clear mid-row, then a clean row 5,6,7,8
    drive(4'h3, 32'h0000_0201); step();
    drive(4'h0, 32'h0); clr = 1'b1; step();
    clr = 1'b0;
    chk("clr_ovf",   32'(bus.o_ovf),   32'd0);
    chk("clr_rows",  32'(bus.o_rows),  32'd0);
    chk("clr_valid", 32'(bus.o_valid), 32'd0);
    bus.i_ready = 1'b0;
    drive(4'hF, 32'h0807_0605); step();
    drive(4'h0, 32'h0);
    chk("clr_gap", 32'(bus.o_valid), 32'd0);
    step();
    chk("clr_valid2", 32'(bus.o_valid), 32'd1);
    chk("clr_data",   bus.o_data,       32'h0807_0605);
    bus.i_ready = 1'b1;
    step();
    chk("clr_empty", 32'(bus.o_valid), 32'd0);
    chk("clr_rows1", 32'(bus.o_rows),  32'd1);
    chk("clr_ovf2",  32'(bus.o_ovf),   32'd0);

    // Reset while stalled with rows buffered
    bus.i_ready = 1'b0;
    drive(4'hF, 32'h1122_3344); step();
    drive(4'hF, 32'h5566_7788); step();
    drive(4'hF, 32'h99AA_BBCC); step();
    drive(4'h0, 32'h0);
    chk("pre_rst_stall", 32'(bus.o_stall), 32'd1);
    chk("pre_rst_valid", 32'(bus.o_valid), 32'd1);
    rst = 1'b1; step();
    rst = 1'b0;
    chk("mrst_valid", 32'(bus.o_valid), 32'd0);
    chk("mrst_data",  bus.o_data,       32'd0);
    chk("mrst_stall", 32'(bus.o_stall), 32'd0);
    chk("mrst_ovf",   32'(bus.o_ovf),   32'd0);
    chk("mrst_rows",  32'(bus.o_rows),  32'd0);

    // Capture gated off
    en = 1'b0;
    drive(4'hF, 32'hFFFF_FFFF); step(); step(); step();
    chk("en_valid", 32'(bus.o_valid), 32'd0);
    chk("en_ovf",   32'(bus.o_ovf),   32'd0);
    en = 1'b1;
    drive(4'h0, 32'h0); step(); step();
    chk("en_valid2", 32'(bus.o_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/oreg_drain.md
Name: oreg_drain

Overview:
- Output-side border block of the binary-parallel systolic array. It is the counterpart to the horizontal input border registers.
- Collects the diagonally-skewed per-column results leaving the array's bottom edge and re-assembles them into aligned rows.
- Buffers rows in a small FIFO and streams them to the downstream writer over a valid/ready handshake.
- Back-pressures the array through o_stall, which the array uses to drop its shift enable.

Parameters:
- WIDTH, 8: signed result width per column.
- COLS, 4: number of array columns drained.
- DEPTH, 2: row FIFO depth in rows; power of two, ≥2.
- CNTW, 16: width of the drained-row counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  capture enable; when low, i_valid is ignored.
- clr  input  1  synchronous soft clear; same effect as rst except it has lower priority.
- i_valid  input  COLS  per-column result strobe from the array bottom edge.
- i_data  input  COLS*WIDTH  signed per-column results; column c is at bits [c*WIDTH +: WIDTH].
- o_stall  output  1  asks the array to freeze.
- o_valid  output  1  an aligned row is available.
- i_ready  input  1  downstream accepts the row.
- o_data  output  COLS*WIDTH  aligned signed row, same packing as i_data.
- o_ovf  output  1  sticky overflow error.
- o_rows  output  CNTW  count of rows popped.

Behaviour:
- Reset:
  - rst (or clr) clears the column flags, hold registers, FIFO pointers and count.
  - All outputs go to 0: o_valid=0, o_data=0, o_stall=0, o_ovf=0, o_rows=0.
  - rst has priority over clr; clr has priority over all other activity.
  - Reset mid-row discards the partial row and all buffered rows.
- Capture:
  - Per column c there is a hold register hold[c] and a flag f[c].
  - When en & i_valid[c] and (!f[c] | commit): hold[c]<=i_data[c] and f[c]<=1.
- Row complete: complete = &f, evaluated on registered flags.
- Commit:
  - commit = complete & !full.
  - Writes {hold} into the FIFO and clears all f that are not being re-set in the same cycle.
  - A same-cycle new i_valid[c] therefore starts the next row without loss.
- Stall: o_stall = complete & full. This is registered-state only; there is no combinational path from i_ready.
- Overflow:
  - If en & i_valid[c] & f[c] & !commit: the data is dropped, hold[c] is unchanged, and o_ovf<=1.
  - o_ovf is sticky until rst/clr.
- FIFO:
  - o_valid = !empty; o_data = head entry.
  - Pop on o_valid & i_ready. A pop while empty is ignored.
  - Push and pop in the same cycle are both legal. When full, a pop frees space, so commit can proceed in the next cycle (not the same cycle).
  - Pointers wrap modulo DEPTH. Full and empty are distinguished by an extra pointer bit.
- Latency: the last column strobe in cycle t (FIFO empty, not full) gives flags full at t+1, a push at end of t+1, and o_valid=1 with that row at t+2.
- o_data must stay stable while o_valid & !i_ready.
- o_rows increments on each pop and wraps at 2^CNTW.
- Arithmetic: no arithmetic on data. Values pass through bit-exact with the sign preserved.

Decomposition:
- Shared package oreg_drain_pkg: typedef row_t (packed array [COLS] of signed [WIDTH-1:0]) and localparam PTRW=$clog2(DEPTH)+1.
- One sub-module, row_fifo: a synchronous FIFO of row_t with push/pop/full/empty, sync active-high reset plus clr.
- The top level holds the deskew flags, hold registers, overflow and counter.

Test Plan:
- Skewed row (COLS=4, WIDTH=8, DEPTH=2): i_valid one-hot 0001,0010,0100,1000 on cycles 0..3 with data 1,-2,3,-4 and i_ready=1 → o_valid at cycle 5 with o_data={-4,3,-2,1} for exactly 1 cycle; o_rows=1.
- Back-pressure:
  - Setup: i_ready=0; push 3 rows with values 10..13, 20..23, 30..33.
  - Expected: the FIFO fills after 2 rows, o_stall=1 once row 3 is complete, and o_data holds row 1 stable.
  - Then raise i_ready: rows pop in order, o_stall drops 1 cycle after the first pop, and all 3 rows exit in order with o_rows=3.
- Overlap: column 0 sends row2 data (0x55) in the same cycle row1 commits → row1 correct, row2 column 0 = 0x55, o_ovf=0.
- Overflow: column 2 strobes twice (7, then 9) while column 3 is still missing → o_ovf=1 sticky, and the row emits column 2 = 7.
- Reset/clear mid-operation: clr after 2 of 4 columns, then a full row 5,6,7,8 → only {8,7,6,5} emerges, o_ovf=0 and o_rows=1. rst asserted with o_valid=1 → all outputs are 0 the next cycle.
- en gating: en=0 with i_valid=1111 → no capture, o_valid stays 0, o_ovf stays 0.
